// File: rtl/syn_fifo_param.sv
// syn_fifo_param: parameterised synchronous FIFO with registered status and error flags.
// Define SYN_FIFO_FWFT_EN for first-word-fall-through reads; default is a registered read port.
module syn_fifo_param #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned AF_LVL = DEPTH - 2,
    parameter int unsigned AE_LVL = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [DATA_W-1:0]      data_in,
    input  logic                   rd_en,
    output logic [DATA_W-1:0]      data_out,
    output logic                   full_o,
    output logic                   emty_o,
    output logic                   almost_full_o,
    output logic                   almost_empty_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   ovf_o,
    output logic                   udf_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DepthC = CW'(DEPTH);
    localparam logic [CW-1:0] AfLvlC = CW'(AF_LVL);
    localparam logic [CW-1:0] AeLvlC = CW'(AE_LVL);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          emty_q, emty_d;
    logic          af_q, af_d;
    logic          ae_q, ae_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          rd_acc, wr_acc;

    // Acceptance depends only on registered flags, so no input-to-flag combinational path.
    always_comb begin
        rd_acc   = rd_en && !emty_q;
        wr_acc   = wr_en && (!full_q || rd_acc);
        wr_ptr_d = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        full_d = (count_d == DepthC);
        emty_d = (count_d == '0);
        af_d   = (count_d >= AfLvlC);
        ae_d   = (count_d <= AeLvlC);
        ovf_d  = wr_en && !wr_acc;
        udf_d  = rd_en && !rd_acc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            emty_q   <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            emty_q   <= emty_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage is intentionally not reset; pointers and count hide any stale contents.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

`ifdef SYN_FIFO_FWFT_EN
    logic [DATA_W-1:0] hold_q;

    // Tracks the presented head word so the output freezes on it once the FIFO drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
        end else if (!emty_q) begin
            hold_q <= mem_q[rd_ptr_q];
        end
    end

    assign data_out = emty_q ? hold_q : mem_q[rd_ptr_q];
`else
    logic [DATA_W-1:0] dout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q <= '0;
        end else if (rd_acc) begin
            dout_q <= mem_q[rd_ptr_q];
        end
    end

    assign data_out = dout_q;
`endif

    assign full_o         = full_q;
    assign emty_o         = emty_q;
    assign almost_full_o  = af_q;
    assign almost_empty_o = ae_q;
    assign count_o        = count_q;
    assign ovf_o          = ovf_q;
    assign udf_o          = udf_q;

endmodule

// File: tb/tb_syn_fifo_param.sv
// Self-checking bench for syn_fifo_param (DATA_W=8, DEPTH=16, default thresholds).
// Works in both read modes; SYN_FIFO_FWFT_EN selects the expected data_out behaviour.
module tb_syn_fifo_param;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] data_in;
    logic       rd_en;
    logic [7:0] data_out;
    logic       full_o, emty_o, almost_full_o, almost_empty_o, ovf_o, udf_o;
    logic [4:0] count_o;

    int n_checks = 0;
    int n_errors = 0;

    syn_fifo_param #(
        .DATA_W(8),
        .DEPTH (DEPTH)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .wr_en         (wr_en),
        .data_in       (data_in),
        .rd_en         (rd_en),
        .data_out      (data_out),
        .full_o        (full_o),
        .emty_o        (emty_o),
        .almost_full_o (almost_full_o),
        .almost_empty_o(almost_empty_o),
        .count_o       (count_o),
        .ovf_o         (ovf_o),
        .udf_o         (udf_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    // Reference model: queue of stored words plus expected pulse/output registers.
    logic [7:0] mq[$];
    logic       m_ovf, m_udf;
    logic [7:0] m_dout, m_last;

    typedef struct {
        logic       wr;
        logic       rd;
        logic [7:0] din;
        int         cnt;
        logic       full;
        logic       empty;
        logic       af;
        logic       ae;
        logic       ovf;
        logic       udf;
        logic [7:0] dreg;
        logic [7:0] dfw;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
        m_dout = 8'h00;
        m_last = 8'h00;
    endtask

    function automatic logic [7:0] exp_dout();
`ifdef SYN_FIFO_FWFT_EN
        return (mq.size() != 0) ? mq[0] : m_last;
`else
        return m_dout;
`endif
    endfunction

    task automatic step(input logic w, input logic r, input logic [7:0] d);
        bit ra, wa;
        wr_en   = w;
        rd_en   = r;
        data_in = d;
        ra = r && (mq.size() != 0);
        wa = w && ((mq.size() != DEPTH) || ra);
        m_ovf = w && !wa;
        m_udf = r && !ra;
        if (mq.size() != 0) m_last = mq[0];
        if (ra) m_dout = mq.pop_front();
        if (wa) mq.push_back(d);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic check_model(input string tag);
        int c;
        c = mq.size();
        chk({tag, ".count"}, int'(count_o), c);
        chk({tag, ".full"}, int'(full_o), int'(c == DEPTH));
        chk({tag, ".empty"}, int'(emty_o), int'(c == 0));
        chk({tag, ".afull"}, int'(almost_full_o), int'(c >= DEPTH - 2));
        chk({tag, ".aempty"}, int'(almost_empty_o), int'(c <= 2));
        chk({tag, ".ovf"}, int'(ovf_o), int'(m_ovf));
        chk({tag, ".udf"}, int'(udf_o), int'(m_udf));
        chk({tag, ".dout"}, int'(data_out), int'(exp_dout()));
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 8'h11, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h11};
        vecs[1]  = '{1'b1, 1'b0, 8'h22, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h11};
        vecs[2]  = '{1'b1, 1'b0, 8'h33, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h11};
        vecs[3]  = '{1'b0, 1'b1, 8'h00, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11, 8'h22};
        vecs[4]  = '{1'b1, 1'b1, 8'h44, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h22, 8'h33};
        vecs[5]  = '{1'b0, 1'b1, 8'h00, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h33, 8'h44};
        vecs[6]  = '{1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h44, 8'h44};
        vecs[7]  = '{1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h44, 8'h44};
        vecs[8]  = '{1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h44, 8'h44};
        vecs[9]  = '{1'b1, 1'b1, 8'h55, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h44, 8'h55};
        vecs[10] = '{1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h55, 8'h55};

        rst     = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        data_in = 8'h00;
        model_reset();
        #1;
        check_model("reset");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed table: short mixed traffic including underflow and write+read on empty.
        for (int i = 0; i < 11; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            step(vecs[i].wr, vecs[i].rd, vecs[i].din);
            chk({tag, ".count"}, int'(count_o), vecs[i].cnt);
            chk({tag, ".full"}, int'(full_o), int'(vecs[i].full));
            chk({tag, ".empty"}, int'(emty_o), int'(vecs[i].empty));
            chk({tag, ".afull"}, int'(almost_full_o), int'(vecs[i].af));
            chk({tag, ".aempty"}, int'(almost_empty_o), int'(vecs[i].ae));
            chk({tag, ".ovf"}, int'(ovf_o), int'(vecs[i].ovf));
            chk({tag, ".udf"}, int'(udf_o), int'(vecs[i].udf));
`ifdef SYN_FIFO_FWFT_EN
            chk({tag, ".dout"}, int'(data_out), int'(vecs[i].dfw));
`else
            chk({tag, ".dout"}, int'(data_out), int'(vecs[i].dreg));
`endif
        end

        // Fill 0..15 then drain, covering every threshold count on the way.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, 8'(i));
            check_model($sformatf("fill%0d", i));
        end
        chk("fill.full_after_16", int'(full_o), 1);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, 8'h00);
            check_model($sformatf("drain%0d", i));
`ifndef SYN_FIFO_FWFT_EN
            chk($sformatf("drain%0d.order", i), int'(data_out), i);
`endif
        end
        chk("drain.empty_after_16", int'(emty_o), 1);

        // Overflow: write 0xAA into a full FIFO.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'(8'h80 + i));
        step(1'b1, 1'b0, 8'hAA);
        check_model("ovf");
        chk("ovf.pulse", int'(ovf_o), 1);
        step(1'b0, 1'b0, 8'h00);
        check_model("ovf_clear");

        // Full with simultaneous read+write for 20 cycles, wrapping both pointers.
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 8'h77);
            check_model($sformatf("rw_full%0d", i));
        end
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, 8'h00);
            check_model($sformatf("rw_drain%0d", i));
        end

        // Asynchronous reset in the middle of a read.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h20 + i));
        step(1'b0, 1'b1, 8'h00);
        rd_en = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_model("rst_mid");
        @(negedge clk);
        rst   = 1'b0;
        rd_en = 1'b0;
        step(1'b1, 1'b0, 8'h3C);
        check_model("post_rst_wr");
        step(1'b0, 1'b1, 8'h00);
        check_model("post_rst_rd");
        chk("post_rst.data", int'(data_out), 8'h3C);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
